// File: rtl/blit_uart_tx.sv
// 8N1 serial transmitter for the host-link byte stream: a small pointer-based
// FIFO feeding a two-process frame FSM with a per-bit reloading baud counter.
module blit_uart_tx #(
    parameter int HZ         = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int DIV   = (HZ + BAUD / 2) / BAUD;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("blit_uart_tx: HZ/BAUD gives a bit period shorter than 2 clocks");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- FIFO ----------------
    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic                empty, full, push, pop;
    logic [7:0]          head;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign in_ready = !rst && !full;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- Frame FSM ----------------
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            bit_end;

    assign bit_end = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = DIV_M1;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = DIV_M1;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = DIV_M1;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        cnt_d   = DIV_M1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE) || !empty;

endmodule
